regbank_access_arbiter: RTL and testbench

//  Clocked front-end sharing the single-ported register bank between three requesters:

---
 rtl/regbank_pkg.sv | 30 +++
 rtl/regbank_arb_prio.sv | 72 +++++++
 rtl/regbank_access_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_regbank_access_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// ---------------------------------------------------------------------------
// regbank_pkg
// Shared definitions for the register-bank access arbiter:
//   REG_W / DATA_W : register index and data widths of the bank
//   PC_REG         : index of the register that mirrors the bank's pcIn
//   state_e        : access FSM states (3-bit encoding)
//   GNT_*          : grant codes produced by the priority selector
// ---------------------------------------------------------------------------
package regbank_pkg;

  localparam int REG_W  = 4;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] PC_REG = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_SETUP = 3'd1,
    ST_WR_HOLD  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_PC_UPD   = 3'd5
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_WB   = 2'd1;
  localparam logic [1:0] GNT_PC   = 2'd2;
  localparam logic [1:0] GNT_DEC  = 2'd3;

endpackage

// File: rtl/regbank_arb_prio.sv
// ---------------------------------------------------------------------------
// regbank_arb_prio
// Combinational grant select for the three requesters plus the decoder
// starvation counter. Priority is wb > pc > dec, except that a decoder which
// has lost MAX_WAIT consecutive arbitrations is granted first.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   arb_valid   : 1 when the arbiter may grant this cycle (FSM idle)
//   wb_req      : writeback request
//   pc_req      : fetch PC-update request
//   dec_req     : decoder read request
//   grant       : GNT_NONE / GNT_WB / GNT_PC / GNT_DEC
// ---------------------------------------------------------------------------
module regbank_arb_prio
  import regbank_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arb_valid,
  input  logic       wb_req,
  input  logic       pc_req,
  input  logic       dec_req,
  output logic [1:0] grant
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic              starved;

  always_comb begin
    starved = (wait_q == WAIT_MAX);
    grant   = GNT_NONE;
    if (arb_valid) begin
      if (dec_req && starved) begin
        grant = GNT_DEC;
      end else if (wb_req) begin
        grant = GNT_WB;
      end else if (pc_req) begin
        grant = GNT_PC;
      end else if (dec_req) begin
        grant = GNT_DEC;
      end
    end
  end

  // Only arbitration cycles with the decoder waiting count as a loss;
  // the count saturates so the forced grant stays armed.
  always_comb begin
    wait_d = wait_q;
    if (arb_valid && dec_req) begin
      if (grant == GNT_DEC) begin
        wait_d = '0;
      end else if (!starved) begin
        wait_d = wait_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

endmodule

// File: rtl/regbank_access_arbiter.sv
// ---------------------------------------------------------------------------
// regbank_access_arbiter
// Shares the single-ported register bank between writeback (write), decoder
// (read) and fetch (PC update). Level req/ack handshakes are converted into
// the bank's toggle triggers; one access is in flight at a time.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   dec_req/dec_addr        : decoder read request and register index
//   dec_ack/dec_data        : 1-cycle ack pulse with registered read data
//   wb_req/wb_addr/wb_data  : writeback write request
//   wb_ack                  : 1-cycle pulse once the write is in the bank
//   pc_req/pc_data, pc_ack  : fetch PC update request and ack pulse
//   rb_trig_r / rb_trig_w   : bank read / write triggers (each toggle = 1 op)
//   rb_addr_r / rb_addr_w   : bank read / write address (held when unused)
//   rb_data_w               : bank write data (held when unused)
//   rb_pc                   : bank pcIn level
//   rb_ready / rb_data_r    : bank readyOut and dataOut
//   busy                    : 1 whenever the FSM is not idle
// ---------------------------------------------------------------------------
module regbank_access_arbiter
  import regbank_pkg::*;
#(
  parameter int RD_LAT   = 2,
  parameter int WR_HOLD  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_req,
  input  logic [REG_W-1:0]  dec_addr,
  output logic              dec_ack,
  output logic [DATA_W-1:0] dec_data,
  input  logic              wb_req,
  input  logic [REG_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ack,
  input  logic              pc_req,
  input  logic [DATA_W-1:0] pc_data,
  output logic              pc_ack,
  output logic              rb_trig_r,
  output logic              rb_trig_w,
  output logic [REG_W-1:0]  rb_addr_r,
  output logic [REG_W-1:0]  rb_addr_w,
  output logic [DATA_W-1:0] rb_data_w,
  output logic [DATA_W-1:0] rb_pc,
  input  logic              rb_ready,
  input  logic [DATA_W-1:0] rb_data_r,
  output logic              busy
);

  localparam logic [7:0] RD_LAST = 8'(RD_LAT - 1);
  localparam logic [7:0] WR_LAST = 8'(WR_HOLD - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              trig_r_q, trig_r_d;
  logic              trig_w_q, trig_w_d;
  logic [REG_W-1:0]  addr_r_q, addr_r_d;
  logic [REG_W-1:0]  addr_w_q, addr_w_d;
  logic [DATA_W-1:0] data_w_q, data_w_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] dec_data_q, dec_data_d;
  logic              dec_ack_q, dec_ack_d;
  logic              wb_ack_q, wb_ack_d;
  logic              pc_ack_q, pc_ack_d;
  logic              rst_sync_q;
  logic              arb_valid;
  logic [1:0]        grant;

  // Arbitration is held off for the first clock after reset release so the
  // first grant happens on a clean, synchronous edge.
  assign arb_valid = (state_q == ST_IDLE) && rst_sync_q;

  regbank_arb_prio #(
    .MAX_WAIT (MAX_WAIT)
  ) u_prio (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_valid (arb_valid),
    .wb_req    (wb_req),
    .pc_req    (pc_req),
    .dec_req   (dec_req),
    .grant     (grant)
  );

  // Every ack is raised while the FSM is still busy; the following cycle is
  // the idle arbitration cycle. A requester that drops its req on seeing the
  // ack is therefore never granted twice for one request.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    trig_r_d   = trig_r_q;
    trig_w_d   = trig_w_q;
    addr_r_d   = addr_r_q;
    addr_w_d   = addr_w_q;
    data_w_d   = data_w_q;
    pc_d       = pc_q;
    dec_data_d = dec_data_q;
    dec_ack_d  = 1'b0;
    wb_ack_d   = 1'b0;
    pc_ack_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        case (grant)
          GNT_WB: begin
            addr_w_d = wb_addr;
            data_w_d = wb_data;
            state_d  = ST_WR_SETUP;
          end
          GNT_PC: begin
            pc_d     = pc_data;
            pc_ack_d = 1'b1;
            state_d  = ST_PC_UPD;
          end
          GNT_DEC: begin
            addr_r_d = dec_addr;
            state_d  = ST_RD_ISSUE;
          end
          default: ;
        endcase
      end

      ST_WR_SETUP: begin
        // addr/data have been stable for a full cycle before this toggle
        trig_w_d = ~trig_w_q;
        cnt_d    = '0;
        state_d  = ST_WR_HOLD;
      end

      ST_WR_HOLD: begin
        if (wb_ack_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == WR_LAST) begin
          wb_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_RD_ISSUE: begin
        trig_r_d = ~trig_r_q;
        cnt_d    = '0;
        state_d  = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        // No timeout: a bank that never signals ready stalls here forever.
        if (dec_ack_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q != RD_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else if (rb_ready) begin
          dec_data_d = rb_data_r;
          dec_ack_d  = 1'b1;
        end
      end

      ST_PC_UPD: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      trig_r_q   <= 1'b0;
      trig_w_q   <= 1'b0;
      addr_r_q   <= '0;
      addr_w_q   <= '0;
      data_w_q   <= '0;
      pc_q       <= '0;
      dec_data_q <= '0;
      dec_ack_q  <= 1'b0;
      wb_ack_q   <= 1'b0;
      pc_ack_q   <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      trig_r_q   <= trig_r_d;
      trig_w_q   <= trig_w_d;
      addr_r_q   <= addr_r_d;
      addr_w_q   <= addr_w_d;
      data_w_q   <= data_w_d;
      pc_q       <= pc_d;
      dec_data_q <= dec_data_d;
      dec_ack_q  <= dec_ack_d;
      wb_ack_q   <= wb_ack_d;
      pc_ack_q   <= pc_ack_d;
      rst_sync_q <= 1'b1;
    end
  end

  assign dec_ack   = dec_ack_q;
  assign dec_data  = dec_data_q;
  assign wb_ack    = wb_ack_q;
  assign pc_ack    = pc_ack_q;
  assign rb_trig_r = trig_r_q;
  assign rb_trig_w = trig_w_q;
  assign rb_addr_r = addr_r_q;
  assign rb_addr_w = addr_w_q;
  assign rb_data_w = data_w_q;
  assign rb_pc     = pc_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_regbank_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regbank_access_arbiter
// Drives the arbiter with directed and random requests, emulates the bank
// behind it, and compares every cycle against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_regbank_access_arbiter;
  import regbank_pkg::*;

  localparam int RD_LAT   = 2;
  localparam int WR_HOLD  = 1;
  localparam int MAX_WAIT = 4;
  localparam int W_WB = 0, W_PC = 1, W_DEC = 2, W_NONE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_req = 1'b0;
  logic [3:0]  dec_addr = '0;
  logic        dec_ack;
  logic [31:0] dec_data;
  logic        wb_req = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        wb_ack;
  logic        pc_req = 1'b0;
  logic [31:0] pc_data = '0;
  logic        pc_ack;
  logic        rb_trig_r, rb_trig_w;
  logic [3:0]  rb_addr_r, rb_addr_w;
  logic [31:0] rb_data_w, rb_pc;
  logic        rb_ready = 1'b1;
  logic [31:0] rb_data_r;
  logic        busy;

  always #5 clk = ~clk;

  regbank_access_arbiter #(
    .RD_LAT(RD_LAT), .WR_HOLD(WR_HOLD), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_req(dec_req), .dec_addr(dec_addr), .dec_ack(dec_ack), .dec_data(dec_data),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack),
    .pc_req(pc_req), .pc_data(pc_data), .pc_ack(pc_ack),
    .rb_trig_r(rb_trig_r), .rb_trig_w(rb_trig_w),
    .rb_addr_r(rb_addr_r), .rb_addr_w(rb_addr_w),
    .rb_data_w(rb_data_w), .rb_pc(rb_pc),
    .rb_ready(rb_ready), .rb_data_r(rb_data_r), .busy(busy)
  );

  // Bank emulation: acts on trigger edges, dataOut valid one cycle later.
  logic [31:0] bank_mem [16];
  logic        trig_r_seen, trig_w_seen;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_r_seen <= 1'b0;
      trig_w_seen <= 1'b0;
      rb_data_r   <= '0;
      for (int i = 0; i < 16; i++) bank_mem[i] <= '0;
    end else begin
      trig_r_seen <= rb_trig_r;
      trig_w_seen <= rb_trig_w;
      if (rb_trig_w != trig_w_seen) bank_mem[rb_addr_w] <= rb_data_w;
      if (rb_trig_r != trig_r_seen)
        rb_data_r <= (rb_addr_r == PC_REG) ? rb_pc : bank_mem[rb_addr_r];
    end
  end

  // Transaction-level reference model
  logic [31:0] m_regs [16];
  logic [31:0] m_pc;
  logic [31:0] m_exp_data;
  logic [3:0]  m_exp_addr;
  int          m_wait, m_who, m_grant_at, m_ack_at, m_nwr, m_nrd;
  int          cyc = 0;
  bit          pend [3];
  bit          rand_en = 1'b0;
  bit          wb_always = 1'b0;
  int          obs_wb_acks = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_pc = '0; m_wait = 0; m_who = W_NONE;
    m_grant_at = cyc - 1; m_ack_at = cyc - 1;
    m_nwr = 0; m_nrd = 0;
    for (int i = 0; i < 3; i++) pend[i] = 1'b0;
    wb_req = 1'b0; pc_req = 1'b0; dec_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wb_req = 1'b0; pc_req = 1'b0; dec_req = 1'b0; rb_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    model_reset();
  endtask

  task automatic new_wb(input logic [3:0] a, input logic [31:0] d);
    wb_addr = a; wb_data = d; wb_req = 1'b1; pend[W_WB] = 1'b1;
  endtask
  task automatic new_pc(input logic [31:0] d);
    pc_data = d; pc_req = 1'b1; pend[W_PC] = 1'b1;
  endtask
  task automatic new_dec(input logic [3:0] a);
    dec_addr = a; dec_req = 1'b1; pend[W_DEC] = 1'b1;
  endtask

  // One cycle: check this cycle's outputs, retire acks, raise new requests,
  // predict the arbitration made at the end of the cycle, advance.
  task automatic step();
    logic [3:0] st_got, st_exp;
    int g;
    st_exp = {(cyc > m_grant_at && cyc <= m_ack_at),
              (m_who == W_WB  && cyc == m_ack_at),
              (m_who == W_PC  && cyc == m_ack_at),
              (m_who == W_DEC && cyc == m_ack_at)};
    st_got = {busy, wb_ack, pc_ack, dec_ack};
    check_eq("status_busy_wb_pc_dec", 32'(st_got), 32'(st_exp));
    if (wb_ack) obs_wb_acks++;
    if (cyc == m_ack_at && m_who != W_NONE) begin
      case (m_who)
        W_WB: begin
          check_eq("wr_addr", 32'(rb_addr_w), 32'(m_exp_addr));
          check_eq("wr_data", rb_data_w, m_exp_data);
          check_eq("wr_trig_parity", 32'(rb_trig_w), 32'(m_nwr[0]));
          $display("txn wb  addr=%0d data=0x%08h cyc=%0d", m_exp_addr, m_exp_data, cyc);
          wb_req = 1'b0;
        end
        W_PC: begin
          check_eq("pc_value", rb_pc, m_exp_data);
          $display("txn pc  data=0x%08h cyc=%0d", m_exp_data, cyc);
          pc_req = 1'b0;
        end
        default: begin
          check_eq("rd_data", dec_data, m_exp_data);
          check_eq("rd_trig_parity", 32'(rb_trig_r), 32'(m_nrd[0]));
          $display("txn dec addr=%0d data=0x%08h cyc=%0d", m_exp_addr, m_exp_data, cyc);
          dec_req = 1'b0;
        end
      endcase
      pend[m_who] = 1'b0;
      m_who = W_NONE;
    end
    if (wb_always && !pend[W_WB]) new_wb(4'($urandom_range(0, 14)), $urandom);
    if (rand_en) begin
      if (!pend[W_WB]  && $urandom_range(0, 3) == 0) new_wb(4'($urandom_range(0, 14)), $urandom);
      if (!pend[W_PC]  && $urandom_range(0, 7) == 0) new_pc($urandom);
      if (!pend[W_DEC] && $urandom_range(0, 2) == 0) new_dec(4'($urandom_range(0, 15)));
    end
    if (cyc > m_ack_at && (pend[W_WB] || pend[W_PC] || pend[W_DEC])) begin
      if (pend[W_DEC] && m_wait == MAX_WAIT) g = W_DEC;
      else if (pend[W_WB]) g = W_WB;
      else if (pend[W_PC]) g = W_PC;
      else g = W_DEC;
      if (g == W_DEC) m_wait = 0;
      else if (pend[W_DEC] && m_wait < MAX_WAIT) m_wait++;
      m_who = g;
      m_grant_at = cyc;
      case (g)
        W_WB: begin
          m_exp_addr = wb_addr; m_exp_data = wb_data;
          m_regs[wb_addr] = wb_data;
          m_nwr++;
          m_ack_at = cyc + 2 + WR_HOLD;
        end
        W_PC: begin
          m_exp_data = pc_data; m_pc = pc_data;
          m_ack_at = cyc + 1;
        end
        default: begin
          m_exp_addr = dec_addr;
          m_exp_data = (dec_addr == PC_REG) ? m_pc : m_regs[dec_addr];
          m_nrd++;
          m_ack_at = cyc + 2 + RD_LAT;
        end
      endcase
    end
    tick();
  endtask

  task automatic run_idle(input int bound);
    int n = 0;
    logic timed_out;
    while ((pend[W_WB] || pend[W_PC] || pend[W_DEC] || cyc <= m_ack_at) && n < bound) begin
      step();
      n++;
    end
    timed_out = (n >= bound);
    check_eq("idle_timeout", 32'(timed_out), 32'd0);
  endtask

  initial begin
    int n, w0;
    logic seen;
    logic [31:0] exp_rd;

    // 1: reset with every request asserted
    rst_n = 1'b0;
    wb_req = 1'b1; pc_req = 1'b1; dec_req = 1'b1;
    wb_addr = 4'd0; wb_data = '0; pc_data = 32'h5; dec_addr = 4'd1;
    repeat (3) tick();
    check_eq("rst_ctrl", 32'({dec_ack, wb_ack, pc_ack, busy, rb_trig_r, rb_trig_w}), 32'd0);
    check_eq("rst_addr", 32'({rb_addr_r, rb_addr_w}), 32'd0);
    check_eq("rst_dec_data", dec_data, 32'd0);
    check_eq("rst_data_w", rb_data_w, 32'd0);
    check_eq("rst_pc", rb_pc, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("release_busy_c1", 32'(busy), 32'd0);
    tick();
    check_eq("release_busy_c2", 32'(busy), 32'd1);
    pc_req = 1'b0; dec_req = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 10) begin
      if (wb_ack) seen = 1'b1; else begin tick(); n++; end
    end
    check_eq("release_wb_ack", 32'(seen), 32'd1);
    check_eq("release_trig_w", 32'(rb_trig_w), 32'd1);
    wb_req = 1'b0;
    tick();
    do_reset();

    // 2: write then read-back of the same register
    new_wb(4'd3, 32'hDEADBEEF);
    run_idle(20);
    new_dec(4'd3);
    run_idle(20);
    check_eq("raw_dec_data", dec_data, 32'hDEADBEEF);

    // 3: all three requesters in the same cycle
    new_wb(4'd5, $urandom);
    new_pc($urandom);
    new_dec(4'd5);
    run_idle(40);

    // 4: permanent writeback vs. decoder, two rounds
    wb_always = 1'b1;
    for (int r = 0; r < 2; r++) begin
      new_dec(4'($urandom_range(0, 15)));
      w0 = obs_wb_acks;
      n = 0;
      while (pend[W_DEC] && n < 100) begin step(); n++; end
      check_eq("starve_wb_acks", 32'(obs_wb_acks - w0), 32'(MAX_WAIT));
    end
    wb_always = 1'b0;
    run_idle(40);

    // 5: PC update seen by a later read of r15
    new_pc(32'h100);
    run_idle(20);
    check_eq("pc_level", rb_pc, 32'h100);
    new_dec(PC_REG);
    run_idle(20);
    check_eq("pc_readback", dec_data, 32'h100);

    // random traffic
    rand_en = 1'b1;
    repeat (300) step();
    rand_en = 1'b0;
    run_idle(100);

    // 6: bank not ready, then reset in the middle of a read
    exp_rd = m_regs[3];
    rb_ready = 1'b0;
    dec_addr = 4'd3; dec_req = 1'b1;
    seen = 1'b0;
    repeat (8) begin tick(); if (dec_ack) seen = 1'b1; end
    check_eq("stall_busy", 32'(busy), 32'd1);
    check_eq("stall_no_ack", 32'(seen), 32'd0);
    rb_ready = 1'b1;
    tick();
    check_eq("stall_release_ack", 32'(dec_ack), 32'd1);
    check_eq("stall_data", dec_data, exp_rd);
    dec_req = 1'b0;
    tick();
    check_eq("stall_back_idle", 32'(busy), 32'd0);

    rb_ready = 1'b0;
    dec_addr = 4'd7; dec_req = 1'b1;
    repeat (4) tick();
    check_eq("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_state", 32'({busy, rb_trig_r, dec_ack}), 32'd0);
    seen = 1'b0;
    repeat (2) begin tick(); if (dec_ack) seen = 1'b1; end
    check_eq("abort_no_ack", 32'(seen), 32'd0);
    do_reset();

    rand_en = 1'b1;
    repeat (150) step();
    rand_en = 1'b0;
    run_idle(100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
